adder_share_ctrl: RTL and testbench
===================================

Name: adder_share_ctrl

Overview:
- Controller that shares one `adder_8bit` combinational datapath between two requesters.
- Each requester submits a job of NUM_OPS packed operands. A round-robin arbiter grants one job at a time.
- The FSM then sequences the adder over the operands, one add per clock, into an accumulator.
- Returns the wrapped sum, an overflow flag and the requester ID through a valid/ready result port.

Parameters:
- WIDTH, 8, operand/sum width in bits; must match `adder_8bit`.
- NUM_OPS, 8, operands per job (≥2).
- IDX_W, 3, index counter width; must equal clog2(NUM_OPS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 job request; held high until gnt0 is seen.
- ops0  in  WIDTH*NUM_OPS  requester 0 operands; operand i is ops0[i*WIDTH +: WIDTH].
- gnt0  out  1  one-cycle pulse; ops0 is captured at the edge that ends this cycle.
- req1  in  1  requester 1 job request.
- ops1  in  WIDTH*NUM_OPS  requester 1 operands.
- gnt1  out  1  one-cycle grant pulse for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  WIDTH  sum of all operands, modulo 2^WIDTH.
- res_ovf  out  1  high if any add in the job produced a carry-out.
- res_id  out  1  requester that owns the result.
- busy  out  1  high in RUN and DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE.
  - gnt0=gnt1=0.
  - res_valid=0, res_sum=0, res_ovf=0, res_id=0, busy=0.
  - acc=0, idx=0.
  - rr_ptr=0, so requester 0 has priority first.
- States: IDLE, RUN, DONE. Encoding is held in the package.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant it regardless of rr_ptr.
  - If both are high, grant the requester rr_ptr points to.
  - The grant is combinational in IDLE: gnt_x=1 for that cycle.
  - On the clock edge: latch ops_x into the operand buffer, set res_id=x, acc=0, ovf=0, idx=0, and rr_ptr = the requester not granted. Go to RUN.
- RUN: each cycle, feed acc and buf[idx] to `adder_8bit`.
  - On the edge: acc <= sum, ovf <= ovf | carry. carry = (sum < acc), evaluated on the pre-update acc.
  - If idx==NUM_OPS-1, go to DONE; otherwise idx <= idx+1.
  - Requests are ignored and no gnt is issued while in RUN or DONE.
- DONE:
  - res_valid=1. res_sum, res_ovf and res_id are stable while res_valid is high.
  - If res_ready=1 at an edge, the handshake completes: res_valid drops next cycle and the state returns to IDLE.
  - res_ready may be held high continuously.
- Latency:
  - Capture edge to res_valid high: exactly NUM_OPS clocks (8 by default).
  - A new grant is possible, at the earliest, in the first IDLE cycle after the result handshake. Minimum job period is NUM_OPS+2 cycles.
- Wrap: sums are modulo 2^WIDTH; 255+1 gives 0 with ovf=1. res_ovf is sticky across all adds of one job and cleared at the next capture.
- Reset mid-operation: the job is aborted silently with no result, all outputs return to reset values, and rr_ptr returns to 0.
- A requester that drops req before being granted is simply not served. The operand buffer guarantees that ops may change after the grant edge.

Decomposition:
- Package `adder_share_pkg`: the state enum (IDLE/RUN/DONE), default WIDTH and NUM_OPS constants, and the requester ID type.
- Sub-module `rr_arbiter_2`: 2-way round-robin arbiter with inputs req[1:0] and rr_ptr, outputs a one-hot grant.
- `adder_share_ctrl` instantiates `rr_arbiter_2` and one `adder_8bit`. The FSM, the operand buffer and the accumulator live in the top module.

Test Plan:
- req0 with ops0={1,2,3,4,5,6,7,8}: gnt0 is a single pulse; res_valid rises 8 clocks after capture with res_sum=36, res_ovf=0, res_id=0.
- req1 with ops1 all 32: res_sum=0, res_ovf=1, res_id=1. Also ops1={255,1,0,0,0,0,0,0}: res_sum=0, res_ovf=1.
- Simultaneous req0 and req1 held continuously after reset:
  - Grants are served in order 0, 1, 0, 1, each in the first IDLE cycle after the previous result handshake.
  - Both requesters are never granted in the same cycle.
- Backpressure: hold res_ready=0 for 5 cycles in DONE. res_valid, res_sum and res_id stay stable, and no gnt is issued. Then res_ready=1 completes the handshake in one cycle.
- Change ops0 to all 0xFF on the cycle after gnt0: the result still reflects the originally captured operands (36).
- Assert rst during RUN at idx=4: all outputs go to 0 immediately, no res_valid appears, and after release a pending req0 and req1 pair is served starting with requester 0.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the shared-adder controller.
package adder_share_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_NUM_OPS = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Requester ID: 0 or 1
    typedef logic req_id_t;

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Requester and result bus of the shared-adder controller.
interface adder_share_ctrl_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_OPS = 8
);
    logic                       req0;
    logic [WIDTH*NUM_OPS-1:0]   ops0;
    logic                       gnt0;
    logic                       req1;
    logic [WIDTH*NUM_OPS-1:0]   ops1;
    logic                       gnt1;
    logic                       res_valid;
    logic                       res_ready;
    logic [WIDTH-1:0]           res_sum;
    logic                       res_ovf;
    logic                       res_id;
    logic                       busy;

    // Requesters and result consumer
    modport master (
        output req0, ops0, req1, ops1, res_ready,
        input  gnt0, gnt1, res_valid, res_sum, res_ovf, res_id, busy
    );

    // Controller
    modport slave (
        input  req0, ops0, req1, ops1, res_ready,
        output gnt0, gnt1, res_valid, res_sum, res_ovf, res_id, busy
    );
endinterface

// File: rtl/adder_8bit.sv
// 8-bit combinational adder; the carry is recovered by the caller.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/adder_share_ctrl_rr_arbiter_2.sv
// Two-way round-robin arbiter; rr_ptr names the requester that wins a tie.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] gnt
);
    // One-hot grant: a lone request always wins, a tie goes to rr_ptr
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one adder_8bit between two requesters; sums NUM_OPS operands per job.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NUM_OPS = DEF_NUM_OPS,
    parameter int unsigned IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    adder_share_ctrl_if.slave  bus
);

    state_t                   state, state_nxt;
    logic [1:0]               req_vec, arb_gnt;
    logic                     rr_ptr;
    logic [WIDTH-1:0]         opbuf [NUM_OPS];
    logic [WIDTH-1:0]         acc, add_sum;
    logic                     ovf;
    req_id_t                  id_q;
    logic [IDX_W-1:0]         idx;
    logic                     last_op, capture;
    logic [WIDTH*NUM_OPS-1:0] ops_sel;

    assign req_vec = {bus.req1, bus.req0};
    assign last_op = (idx == IDX_W'(NUM_OPS - 1));
    assign capture = (state == S_IDLE) && (arb_gnt != 2'b00);
    assign ops_sel = arb_gnt[1] ? bus.ops1 : bus.ops0;

    rr_arbiter_2 u_arb (
        .req    (req_vec),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt)
    );

    adder_8bit u_add (
        .a   (acc),
        .b   (opbuf[idx]),
        .sum (add_sum)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (capture) state_nxt = S_RUN;
            S_RUN:   if (last_op) state_nxt = S_DONE;
            S_DONE:  if (bus.res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; grants are combinational in IDLE and forced low during reset
    always_comb begin
        bus.gnt0      = 1'b0;
        bus.gnt1      = 1'b0;
        if (state == S_IDLE && !rst) begin
            bus.gnt0 = arb_gnt[0];
            bus.gnt1 = arb_gnt[1];
        end
        bus.res_valid = (state == S_DONE);
        bus.busy      = (state != S_IDLE);
        bus.res_sum   = acc;
        bus.res_ovf   = ovf;
        bus.res_id    = id_q;
    end

    // Operand capture, accumulation and round-robin pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_OPS; i++) opbuf[i] <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
            id_q   <= 1'b0;
            idx    <= '0;
            rr_ptr <= 1'b0;
        end else if (capture) begin
            for (int unsigned i = 0; i < NUM_OPS; i++)
                opbuf[i] <= ops_sel[i*WIDTH +: WIDTH];
            acc    <= '0;
            ovf    <= 1'b0;
            id_q   <= arb_gnt[1];
            idx    <= '0;
            rr_ptr <= arb_gnt[0];
        end else if (state == S_RUN) begin
            acc <= add_sum;
            // A wrapped sum is smaller than the pre-add accumulator
            ovf <= ovf | (add_sum < acc);
            if (!last_op) idx <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed self-checking bench for adder_share_ctrl.
module tb_adder_share_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    adder_share_ctrl_if #(.WIDTH(8), .NUM_OPS(8)) bus ();

    adder_share_ctrl #(.WIDTH(8), .NUM_OPS(8), .IDX_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_no_gnt(input string tag);
        check({tag, "_gnt0"}, 32'(bus.gnt0), 32'd0);
        check({tag, "_gnt1"}, 32'(bus.gnt1), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.res_ready = 1'b0;
        bus.ops0      = '0;
        bus.ops1      = '0;
        tick();
        tick();

        // Reset state
        check_no_gnt("rst");
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_sum",   32'(bus.res_sum),   32'd0);
        check("rst_ovf",   32'(bus.res_ovf),   32'd0);
        check("rst_id",    32'(bus.res_id),    32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        rst = 1'b0;
        tick();

        // Job 1: requester 0, operands 1..8 -> 36; ops0 trashed after grant
        for (int i = 0; i < 8; i++) bus.ops0[i*8 +: 8] = 8'(i + 1);
        bus.req0 = 1'b1;
        #1;
        check("j1_gnt0", 32'(bus.gnt0), 32'd1);
        check("j1_gnt1", 32'(bus.gnt1), 32'd0);
        tick();
        bus.req0 = 1'b0;
        bus.ops0 = '1;
        check("j1_gnt0_pulse", 32'(bus.gnt0), 32'd0);
        check("j1_busy", 32'(bus.busy), 32'd1);
        repeat (7) tick();
        check("j1_valid_early", 32'(bus.res_valid), 32'd0);
        tick();
        check("j1_valid", 32'(bus.res_valid), 32'd1);
        check("j1_sum",   32'(bus.res_sum),   32'd36);
        check("j1_ovf",   32'(bus.res_ovf),   32'd0);
        check("j1_id",    32'(bus.res_id),    32'd0);

        // Backpressure with requester 1 waiting; ops1 all 32
        for (int i = 0; i < 8; i++) bus.ops1[i*8 +: 8] = 8'd32;
        bus.req1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_valid", 32'(bus.res_valid), 32'd1);
            check("bp_sum",   32'(bus.res_sum),   32'd36);
            check("bp_id",    32'(bus.res_id),    32'd0);
            check_no_gnt("bp");
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("hs1_valid", 32'(bus.res_valid), 32'd0);
        check("hs1_busy",  32'(bus.busy),      32'd0);
        check("j2_gnt1",   32'(bus.gnt1),      32'd1);
        check("j2_gnt0",   32'(bus.gnt0),      32'd0);

        // Job 2: 8*32 = 256 -> 0 with overflow
        tick();
        bus.req1 = 1'b0;
        repeat (7) tick();
        check("j2_valid_early", 32'(bus.res_valid), 32'd0);
        tick();
        check("j2_valid", 32'(bus.res_valid), 32'd1);
        check("j2_sum",   32'(bus.res_sum),   32'd0);
        check("j2_ovf",   32'(bus.res_ovf),   32'd1);
        check("j2_id",    32'(bus.res_id),    32'd1);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("hs2_valid", 32'(bus.res_valid), 32'd0);

        // Job 3: requester 1, {255,1,0,...} -> 0 with overflow on the second add
        bus.ops1 = '0;
        bus.ops1[7:0]  = 8'd255;
        bus.ops1[15:8] = 8'd1;
        bus.req1 = 1'b1;
        #1;
        check("j3_gnt1", 32'(bus.gnt1), 32'd1);
        tick();
        bus.req1 = 1'b0;
        repeat (8) tick();
        check("j3_valid", 32'(bus.res_valid), 32'd1);
        check("j3_sum",   32'(bus.res_sum),   32'd0);
        check("j3_ovf",   32'(bus.res_ovf),   32'd1);
        check("j3_id",    32'(bus.res_id),    32'd1);
        bus.res_ready = 1'b1;
        tick();

        // Both requesters held, res_ready held: order 0,1,0,1, period 10
        for (int i = 0; i < 8; i++) begin
            bus.ops0[i*8 +: 8] = 8'(i + 1);
            bus.ops1[i*8 +: 8] = 8'd1;
        end
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("alt_gnt0", 32'(bus.gnt0), 32'((j % 2) == 0));
            check("alt_gnt1", 32'(bus.gnt1), 32'((j % 2) == 1));
            tick();
            for (int k = 0; k < 7; k++) begin
                check_no_gnt("alt_run");
                tick();
            end
            check("alt_valid_early", 32'(bus.res_valid), 32'd0);
            tick();
            check("alt_valid", 32'(bus.res_valid), 32'd1);
            check("alt_id",    32'(bus.res_id),    32'(j % 2));
            check("alt_sum",   32'(bus.res_sum),   ((j % 2) == 0) ? 32'd36 : 32'd8);
            check("alt_ovf",   32'(bus.res_ovf),   32'd0);
            check_no_gnt("alt_done");
            tick();
        end

        // Reset at idx=4 of a requester-0 job
        #1;
        check("pre_rst_gnt0", 32'(bus.gnt0), 32'd1);
        tick();
        repeat (4) tick();
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_no_gnt("mid_rst");
        check("mid_rst_busy",  32'(bus.busy),      32'd0);
        check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_sum",   32'(bus.res_sum),   32'd0);
        check("mid_rst_ovf",   32'(bus.res_ovf),   32'd0);
        check("mid_rst_id",    32'(bus.res_id),    32'd0);
        tick();
        tick();
        check("mid_rst_valid2", 32'(bus.res_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_gnt0", 32'(bus.gnt0), 32'd1);
        check("post_rst_gnt1", 32'(bus.gnt1), 32'd0);
        for (int j = 0; j < 2; j++) begin
            tick();
            repeat (8) tick();
            check("post_valid", 32'(bus.res_valid), 32'd1);
            check("post_id",    32'(bus.res_id),    32'(j));
            check("post_sum",   32'(bus.res_sum),   (j == 0) ? 32'd36 : 32'd8);
            tick();
            if (j == 0) begin
                check("post_gnt1", 32'(bus.gnt1), 32'd1);
                check("post_gnt0", 32'(bus.gnt0), 32'd0);
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.res_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
